// File: rtl/serial_magnitude_comparator.sv
// Serial unsigned magnitude comparator: captures A/B on an accepted start,
// then resolves one bit pair per clock, MSB first, and publishes a registered
// one-hot greater/equal/less result together with a one-cycle done pulse.
//
// Handshake: start is a request that is only looked at in IDLE; it is
// accepted on the edge where state is IDLE and start is high. busy is high
// for every cycle the block spends in COMPARE. done pulses for exactly one
// cycle, in the same cycle the result outputs take their new value. A start
// presented while busy is high is dropped, not queued.
module serial_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_greater,
  output logic             A_equal,
  output logic             A_less
);

  // Bit index needs at least one bit even when WIDTH is 1.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  // state_q is the FSM state; probe it hierarchically when debugging.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [IW-1:0]    idx_q;
  logic             decided_q;
  logic             dec_gt_q;

  logic             a_bit, b_bit, bit_diff, last_bit;
  logic             load_res, res_gt, res_eq;

  // The bit under evaluation always sits at the top of the shift registers.
  assign a_bit    = a_sr[WIDTH-1];
  assign b_bit    = b_sr[WIDTH-1];
  assign bit_diff = a_bit ^ b_bit;
  assign last_bit = (idx_q == '0);
  assign busy     = (state_q == COMPARE);

  // Next-state and result decision for the current bit pair.
  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
    res_gt   = 1'b0;
    res_eq   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = COMPARE;
      end
      COMPARE: begin
        if (EARLY_EXIT) begin
          // First differing bit settles the answer; equal to the end means equal.
          if (bit_diff) begin
            load_res = 1'b1;
            res_gt   = a_bit;
          end else if (last_bit) begin
            load_res = 1'b1;
            res_eq   = 1'b1;
          end
        end else if (last_bit) begin
          // Fixed latency: answer comes from the sticky flag or the final bit.
          load_res = 1'b1;
          if (decided_q)     res_gt = dec_gt_q;
          else if (bit_diff) res_gt = a_bit;
          else               res_eq = 1'b1;
        end
        if (load_res) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand shift registers, bit index and sticky first-difference flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      dec_gt_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        a_sr      <= A;
        b_sr      <= B;
        idx_q     <= IW'(WIDTH - 1);
        decided_q <= 1'b0;
        dec_gt_q  <= 1'b0;
      end
    end else begin
      a_sr  <= a_sr << 1;
      b_sr  <= b_sr << 1;
      idx_q <= idx_q - IW'(1);
      if (!decided_q && bit_diff) begin
        decided_q <= 1'b1;
        dec_gt_q  <= a_bit;
      end
    end
  end

  // Registered one-hot result, held until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      A_greater <= 1'b0;
      A_equal   <= 1'b0;
      A_less    <= 1'b0;
    end else begin
      done <= load_res;
      if (load_res) begin
        A_greater <= res_gt;
        A_equal   <= res_eq;
        A_less    <= !res_gt && !res_eq;
      end
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: one early-exit and one fixed-latency
// instance, directed cases plus random operands checked against a plain
// arithmetic model of result and latency.
module tb_serial_magnitude_comparator;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: EARLY_EXIT=1, index 1: EARLY_EXIT=0.
  logic [1:0]   start_w;
  logic [W-1:0] a_w [2];
  logic [W-1:0] b_w [2];
  logic [1:0]   busy_w, done_w;
  logic [1:0]   gt_w, eq_w, lt_w;

  serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .A(a_w[0]), .B(b_w[0]),
    .busy(busy_w[0]), .done(done_w[0]),
    .A_greater(gt_w[0]), .A_equal(eq_w[0]), .A_less(lt_w[0])
  );

  serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .A(a_w[1]), .B(b_w[1]),
    .busy(busy_w[1]), .done(done_w[1]),
    .A_greater(gt_w[1]), .A_equal(eq_w[1]), .A_less(lt_w[1])
  );

  // ---------------- scoreboard ----------------
  // Entry = {expected latency[7:0], expected {gt,eq,lt}}.
  logic [10:0] exp_q [$];
  logic [2:0]  held [2];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] res_of(input int u);
    return {gt_w[u], eq_w[u], lt_w[u]};
  endfunction

  // Reference: unsigned compare; latency from the highest differing bit.
  function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b)  return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_lat(input int u, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
    if (u == 1 || x == '0) return W;
    for (int i = W - 1; i >= 0; i--)
      if (x[i]) return W - i;
    return W;
  endfunction

  task automatic push_exp(input int u, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    lat = model_lat(u, a, b);
    exp_q.push_back({lat[7:0], model_res(a, b)});
  endtask

  // ---------------- driver tasks ----------------
  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the accepting edge; waits for done and checks it.
  task automatic wait_done(input int u, input bit scramble);
    int k;
    bit got;
    logic [10:0] e;
    k = 0;
    got = 1'b0;
    while (!got && k < 4 * W) begin
      if (scramble) begin
        a_w[u] = W'($urandom);
        b_w[u] = W'($urandom);
      end
      tick();
      k++;
      if (done_w[u]) got = 1'b1;
      else begin
        check("busy_during", busy_w[u], 1'b1);
        check("res_hold_during", res_of(u), held[u]);
      end
    end
    check("done_seen", got, 1'b1);
    e = exp_q.pop_front();
    check("latency", k, e[10:3]);
    check("result", res_of(u), e[2:0]);
    check("busy_at_done", busy_w[u], 1'b0);
    held[u] = e[2:0];
  endtask

  task automatic compare_op(input int u, input logic [W-1:0] a, input logic [W-1:0] b);
    start_w[u] = 1'b1;
    a_w[u] = a;
    b_w[u] = b;
    push_exp(u, a, b);
    tick();
    start_w[u] = 1'b0;
    check("busy_accept", busy_w[u], 1'b1);
    wait_done(u, 1'b0);
    tick();
    check("done_one_cycle", done_w[u], 1'b0);
  endtask

  // Start held high, operands scrambled during compare, restart right after done.
  task automatic hold_start_op(input int u);
    logic [W-1:0] na, nb;
    start_w[u] = 1'b1;
    a_w[u] = 8'h00;
    b_w[u] = 8'hFF;
    push_exp(u, 8'h00, 8'hFF);
    tick();
    wait_done(u, 1'b1);
    na = W'($urandom);
    nb = W'($urandom);
    a_w[u] = na;
    b_w[u] = nb;
    push_exp(u, na, nb);
    tick();
    start_w[u] = 1'b0;
    check("restart_accept", busy_w[u], 1'b1);
    check("done_dropped", done_w[u], 1'b0);
    wait_done(u, 1'b0);
    tick();
    check("done_one_cycle", done_w[u], 1'b0);
  endtask

  task automatic idle_check(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_done", done_w[u], 1'b0);
      check("idle_busy", busy_w[u], 1'b0);
      check("idle_hold", res_of(u), held[u]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] ra, rb;
    start_w = '0;
    a_w[0] = '0; b_w[0] = '0; a_w[1] = '0; b_w[1] = '0;
    held[0] = 3'b000;
    held[1] = 3'b000;
    #12;
    for (int u = 0; u < 2; u++) begin
      check("rst_busy", busy_w[u], 1'b0);
      check("rst_done", done_w[u], 1'b0);
      check("rst_res", res_of(u), 3'b000);
    end
    tick();
    rst_n = 1'b1;
    tick();

    // Directed cases, early exit.
    compare_op(0, 8'h80, 8'h7F);
    idle_check(0, 20);
    compare_op(0, 8'h34, 8'h3C);
    compare_op(0, 8'hA5, 8'hA5);

    // Directed cases, fixed latency.
    compare_op(1, 8'h80, 8'h7F);
    compare_op(1, 8'h12, 8'h13);
    compare_op(1, 8'h77, 8'h77);

    // Start held during compare with changing operands.
    hold_start_op(0);
    hold_start_op(1);

    // Asynchronous reset in the middle of an equal compare.
    start_w[0] = 1'b1;
    a_w[0] = 8'hA5;
    b_w[0] = 8'hA5;
    tick();
    start_w[0] = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    held[0] = 3'b000;
    held[1] = 3'b000;
    for (int u = 0; u < 2; u++) begin
      check("async_rst_busy", busy_w[u], 1'b0);
      check("async_rst_done", done_w[u], 1'b0);
      check("async_rst_res", res_of(u), 3'b000);
    end
    tick(); tick();
    rst_n = 1'b1;
    idle_check(0, 10);
    compare_op(0, 8'h55, 8'h55);

    // Random operands on both instances.
    for (int n = 0; n < 60; n++) begin
      int u;
      u = n % 2;
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      compare_op(u, ra, rb);
      idle_check(u, $urandom_range(0, 3));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Multi-bit magnitude comparator built around the single-bit compare stage, evaluating one bit pair per clock, MSB first. Parallel A/B operands are captured on a start handshake. The block emits registered, one-hot A_greater/A_equal/A_less results with a one-cycle done pulse. It sits downstream of the 1-bit comparator in the comparator family and extends it to WIDTH-bit operands with minimal combinational logic.

Parameters:
WIDTH, 8, operand width in bits (>= 1)
EARLY_EXIT, 1, 1 = finish on first differing bit; 0 = always scan all WIDTH bits (fixed latency)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  operand A; captured when start accepted
B  input  WIDTH  operand B; captured when start accepted
busy  output  1  high while in COMPARE
done  output  1  one-cycle pulse when result registers update
A_greater  output  1  registered result, A > B (unsigned)
A_equal  output  1  registered result, A == B
A_less  output  1  registered result, A < B (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0; done=0; A_greater=0, A_equal=0, A_less=0; shift registers, bit index and decided flag cleared. Reset mid-compare aborts the operation; no done is issued.
- Comparison is unsigned.
- States: IDLE, COMPARE.
- IDLE:
  - start=1 at edge E0: capture A and B into shift registers; idx=WIDTH-1; decided=0; go to COMPARE; busy=1 from E0.
  - start=0: stay in IDLE.
- COMPARE: edge Ek (k=1..WIDTH) evaluates bit idx = WIDTH-k.
  - a>b at that bit, not yet decided: result=greater.
  - a<b at that bit, not yet decided: result=less.
  - Equal bit: continue.
  - EARLY_EXIT=1: on first mismatch at edge Ek, load result registers, pulse done, go to IDLE, busy=0, all at Ek. If all bits are equal, at edge E_WIDTH: A_equal=1, done pulse, go to IDLE.
  - EARLY_EXIT=0: first mismatch sets a sticky decided flag with its result; later bits are ignored. Result load, done and return to IDLE always occur at edge E_WIDTH.
- Latency: start accept to done is k cycles, where k = (WIDTH − index of first differing bit), or WIDTH if the operands are equal or EARLY_EXIT=0. The minimum is 1 cycle.
- Result outputs:
  - Registered, exactly one-hot after the first done.
  - Held stable until the next done; not cleared when a new start is accepted.
  - All zero only between reset and the first done.
- done is high for exactly one cycle per accepted start.
- start while busy=1 (including the edge at which done asserts) is ignored; operands are not re-captured. A new start is accepted at the earliest on the edge after done.
- Changes on A/B after capture have no effect on the result in progress.
- WIDTH=1: decision is always at E1.

Test Plan:
- WIDTH=8, EARLY_EXIT=1, A=0x80, B=0x7F, start pulse at E0 -> done at E1, A_greater=1, others 0, busy high for exactly 1 cycle.
- A=0x34, B=0x3C (first differing bit is bit 3) -> done at E5, A_less=1. Then A=0xA5, B=0xA5 -> done at E8, A_equal=1.
- EARLY_EXIT=0, A=0x80, B=0x7F -> done at E8 (not E1), A_greater=1. Then A=0x12, B=0x13 -> done at E8, A_less=1.
- Start 0x00 vs 0xFF, then change A/B and hold start=1 during COMPARE -> only one done, result A_less=1. Second start sampled the cycle after done -> accepted with the new operands.
- Assert rst_n=0 at E3 of an 8-cycle equal compare -> all outputs 0 immediately (asynchronous); no done. After release, a fresh 0x55 vs 0x55 compare -> done at E8, A_equal=1.
- Results hold across idle: after A_greater=1, wait 20 cycles with start=0 -> outputs unchanged, done stays 0.
